// File: rtl/l1tlb_miss_port.sv
// l1tlb_miss_port: turns L1TLB misses into L2TLB requests, tracks them by rid, routes acks to fills and snoops to invalidates.
// Define L1TLB_MISS_MERGE_EN to merge misses that hit a pending, unpoisoned entry.
module l1tlb_miss_port #(
    parameter int NUM_RID  = 4,
    parameter int HPADDR_W = 11,
    parameter int PPADDR_W = 14,
    parameter int DCTLBE_W = 8,
    localparam int RID_W = NUM_RID > 1 ? $clog2(NUM_RID) : 1,
    localparam int TBL   = 1 << RID_W,
    localparam int REQ_W = RID_W + HPADDR_W,
    localparam int ACK_W = REQ_W + PPADDR_W + DCTLBE_W,
    localparam int CNT_W = $clog2(NUM_RID + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                miss_valid,
    output logic                miss_retry,
    input  logic [HPADDR_W-1:0] miss_hpaddr,
    output logic                l1tlbtol2tlb_req_valid,
    input  logic                l1tlbtol2tlb_req_retry,
    output logic [REQ_W-1:0]    l1tlbtol2tlb_req,
    input  logic                l2tlbtol1tlb_ack_valid,
    output logic                l2tlbtol1tlb_ack_retry,
    input  logic [ACK_W-1:0]    l2tlbtol1tlb_ack,
    input  logic                l2tlbtol1tlb_snoop_valid,
    output logic                l2tlbtol1tlb_snoop_retry,
    input  logic [REQ_W-1:0]    l2tlbtol1tlb_snoop,
    output logic                l1tlbtol2tlb_sack_valid,
    input  logic                l1tlbtol2tlb_sack_retry,
    output logic [RID_W-1:0]    l1tlbtol2tlb_sack,
    output logic                fill_valid,
    input  logic                fill_retry,
    output logic [ACK_W-1:0]    fill,
    output logic                inv_valid,
    output logic [HPADDR_W-1:0] inv_hpaddr,
    output logic [CNT_W-1:0]    outstanding,
    output logic                err_bad_rid
);
    // Table is sized to a power of two so any rid on the wire indexes safely; entries >= NUM_RID never allocate.
    logic [TBL-1:0]      busy_q, busy_d, pois_q, pois_d;
    logic [HPADDR_W-1:0] hpa_q [TBL];
    logic [HPADDR_W-1:0] hpa_d [TBL];
    logic                req_valid_q, req_valid_d, fill_valid_q, fill_valid_d;
    logic                inv_valid_q, inv_valid_d, sack_valid_q, sack_valid_d, err_q, err_d;
    logic [REQ_W-1:0]    req_q, req_d;
    logic [ACK_W-1:0]    fill_q, fill_d;
    logic [HPADDR_W-1:0] inv_hpaddr_q, inv_hpaddr_d;
    logic [RID_W-1:0]    sack_q, sack_d, free_rid, ack_rid;
    logic [CNT_W-1:0]    out_q, out_d;
    logic [HPADDR_W-1:0] snp_hpa;
    logic                full, match, miss_fire, alloc, ack_fire, ack_ok, ack_pois, snp_fire, do_fill;

    assign ack_rid  = l2tlbtol1tlb_ack[ACK_W-1 -: RID_W];
    assign snp_hpa  = l2tlbtol1tlb_snoop[HPADDR_W-1:0];
    assign full     = &busy_q[NUM_RID-1:0];

    always_comb begin
        free_rid = '0;
        for (int i = NUM_RID - 1; i >= 0; i--)
            free_rid = busy_q[i] ? free_rid : RID_W'(i);
    end

`ifdef L1TLB_MISS_MERGE_EN
    // A snoop on the same address this cycle kills the match, so the miss gets a fresh, clean entry.
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < NUM_RID; i++)
            match = match || (busy_q[i] && !pois_q[i] && hpa_q[i] == miss_hpaddr);
        match = match && !(snp_fire && snp_hpa == miss_hpaddr);
    end
`else
    assign match = 1'b0;
`endif

    assign miss_retry               = !match && (full || (req_valid_q && l1tlbtol2tlb_req_retry));
    assign miss_fire                = miss_valid && !miss_retry;
    assign alloc                    = miss_fire && !match;
    assign l2tlbtol1tlb_ack_retry   = fill_valid_q && fill_retry;
    assign ack_fire                 = l2tlbtol1tlb_ack_valid && !l2tlbtol1tlb_ack_retry;
    assign ack_ok                   = busy_q[ack_rid];
    assign ack_pois                 = pois_q[ack_rid] || (snp_fire && snp_hpa == hpa_q[ack_rid]);
    assign do_fill                  = ack_fire && ack_ok && !ack_pois;
    assign l2tlbtol1tlb_snoop_retry = sack_valid_q && l1tlbtol2tlb_sack_retry;
    assign snp_fire                 = l2tlbtol1tlb_snoop_valid && !l2tlbtol1tlb_snoop_retry;

    always_comb begin
        busy_d = busy_q;
        pois_d = pois_q;
        hpa_d  = hpa_q;
        out_d  = '0;
        for (int i = 0; i < TBL; i++) begin
            if (snp_fire && busy_q[i] && hpa_q[i] == snp_hpa) pois_d[i] = 1'b1;
            if (ack_fire && ack_ok && ack_rid == RID_W'(i)) begin
                busy_d[i] = 1'b0;
                pois_d[i] = 1'b0;
            end
            if (alloc && free_rid == RID_W'(i)) begin
                busy_d[i] = 1'b1;
                pois_d[i] = 1'b0;
                hpa_d[i]  = miss_hpaddr;
            end
        end
        for (int i = 0; i < NUM_RID; i++)
            out_d = out_d + CNT_W'(busy_d[i]);
    end

    assign req_valid_d  = alloc || (req_valid_q && l1tlbtol2tlb_req_retry);
    assign req_d        = alloc ? {free_rid, miss_hpaddr} : req_q;
    assign fill_valid_d = do_fill || (fill_valid_q && fill_retry);
    assign fill_d       = do_fill ? l2tlbtol1tlb_ack : fill_q;
    assign inv_valid_d  = snp_fire;
    assign inv_hpaddr_d = snp_fire ? snp_hpa : inv_hpaddr_q;
    assign sack_valid_d = snp_fire || (sack_valid_q && l1tlbtol2tlb_sack_retry);
    assign sack_d       = snp_fire ? l2tlbtol1tlb_snoop[REQ_W-1 -: RID_W] : sack_q;
    assign err_d        = err_q || (ack_fire && !ack_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q       <= '0;
            pois_q       <= '0;
            for (int i = 0; i < TBL; i++) hpa_q[i] <= '0;
            req_valid_q  <= 1'b0;
            req_q        <= '0;
            fill_valid_q <= 1'b0;
            fill_q       <= '0;
            inv_valid_q  <= 1'b0;
            inv_hpaddr_q <= '0;
            sack_valid_q <= 1'b0;
            sack_q       <= '0;
            err_q        <= 1'b0;
            out_q        <= '0;
        end else begin
            busy_q       <= busy_d;
            pois_q       <= pois_d;
            hpa_q        <= hpa_d;
            req_valid_q  <= req_valid_d;
            req_q        <= req_d;
            fill_valid_q <= fill_valid_d;
            fill_q       <= fill_d;
            inv_valid_q  <= inv_valid_d;
            inv_hpaddr_q <= inv_hpaddr_d;
            sack_valid_q <= sack_valid_d;
            sack_q       <= sack_d;
            err_q        <= err_d;
            out_q        <= out_d;
        end
    end

    assign l1tlbtol2tlb_req_valid  = req_valid_q;
    assign l1tlbtol2tlb_req        = req_q;
    assign fill_valid              = fill_valid_q;
    assign fill                    = fill_q;
    assign inv_valid               = inv_valid_q;
    assign inv_hpaddr              = inv_hpaddr_q;
    assign l1tlbtol2tlb_sack_valid = sack_valid_q;
    assign l1tlbtol2tlb_sack       = sack_q;
    assign outstanding             = out_q;
    assign err_bad_rid             = err_q;
endmodule

// File: tb/tb_l1tlb_miss_port.sv
// tb_l1tlb_miss_port: scoreboard bench for l1tlb_miss_port; expected req/fill/sack/inv payloads are queued as stimulus is driven.
module tb_l1tlb_miss_port;
    localparam int REQ_W = 13;
    localparam int ACK_W = 35;

    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;

    logic              miss_valid = 0, miss_retry;
    logic [10:0]       miss_hpaddr = '0;
    logic              req_valid, req_retry = 0;
    logic [REQ_W-1:0]  req;
    logic              ack_valid = 0, ack_retry;
    logic [ACK_W-1:0]  ack = '0;
    logic              snoop_valid = 0, snoop_retry;
    logic [REQ_W-1:0]  snoop = '0;
    logic              sack_valid, sack_retry = 0;
    logic [1:0]        sack;
    logic              fill_valid, fill_retry = 0;
    logic [ACK_W-1:0]  fill;
    logic              inv_valid;
    logic [10:0]       inv_hpaddr;
    logic [2:0]        outstanding;
    logic              err_bad_rid;

    l1tlb_miss_port dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_retry(miss_retry), .miss_hpaddr(miss_hpaddr),
        .l1tlbtol2tlb_req_valid(req_valid), .l1tlbtol2tlb_req_retry(req_retry), .l1tlbtol2tlb_req(req),
        .l2tlbtol1tlb_ack_valid(ack_valid), .l2tlbtol1tlb_ack_retry(ack_retry), .l2tlbtol1tlb_ack(ack),
        .l2tlbtol1tlb_snoop_valid(snoop_valid), .l2tlbtol1tlb_snoop_retry(snoop_retry), .l2tlbtol1tlb_snoop(snoop),
        .l1tlbtol2tlb_sack_valid(sack_valid), .l1tlbtol2tlb_sack_retry(sack_retry), .l1tlbtol2tlb_sack(sack),
        .fill_valid(fill_valid), .fill_retry(fill_retry), .fill(fill),
        .inv_valid(inv_valid), .inv_hpaddr(inv_hpaddr),
        .outstanding(outstanding), .err_bad_rid(err_bad_rid)
    );

    int n_cmp = 0, n_bad = 0;
    logic [REQ_W-1:0] exp_req [$];
    logic [ACK_W-1:0] exp_fill [$];
    logic [1:0]       exp_sack [$];
    logic [10:0]      exp_inv [$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [ACK_W-1:0] mk_ack(input logic [1:0] r, input logic [10:0] h,
                                                input logic [13:0] p, input logic [7:0] d);
        return {r, h, p, d};
    endfunction

    always @(negedge clk) if (!reset) begin
        if (req_valid && !req_retry) begin
            if (exp_req.size() == 0) chk("req_unexpected", req_valid, 0);
            else chk("req", req, exp_req.pop_front());
        end
        if (fill_valid && !fill_retry) begin
            if (exp_fill.size() == 0) chk("fill_unexpected", fill_valid, 0);
            else chk("fill", fill, exp_fill.pop_front());
        end
        if (sack_valid && !sack_retry) begin
            if (exp_sack.size() == 0) chk("sack_unexpected", sack_valid, 0);
            else chk("sack", sack, exp_sack.pop_front());
        end
        if (inv_valid) begin
            if (exp_inv.size() == 0) chk("inv_unexpected", inv_valid, 0);
            else chk("inv", inv_hpaddr, exp_inv.pop_front());
        end
    end

    task automatic do_miss(input logic [10:0] a);
        int k;
        @(posedge clk) #1;
        miss_valid = 1; miss_hpaddr = a;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (!miss_retry) break; end
        if (k == 50) chk("miss_timeout", miss_retry, 0);
        @(posedge clk) #1;
        miss_valid = 0;
    endtask

    task automatic do_ack(input logic [ACK_W-1:0] a);
        int k;
        @(posedge clk) #1;
        ack_valid = 1; ack = a;
        for (k = 0; k < 50; k++) begin @(negedge clk); if (!ack_retry) break; end
        if (k == 50) chk("ack_timeout", ack_retry, 0);
        @(posedge clk) #1;
        ack_valid = 0;
    endtask

    task automatic do_snoop(input logic [1:0] r, input logic [10:0] a);
        int k;
        @(posedge clk) #1;
        snoop_valid = 1; snoop = {r, a};
        for (k = 0; k < 50; k++) begin @(negedge clk); if (!snoop_retry) break; end
        if (k == 50) chk("snoop_timeout", snoop_retry, 0);
        @(posedge clk) #1;
        snoop_valid = 0;
    endtask

    task automatic fill_ack(input logic [1:0] r, input logic [10:0] h, input logic [13:0] p);
        exp_fill.push_back(mk_ack(r, h, p, 8'h5A));
        do_ack(mk_ack(r, h, p, 8'h5A));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        // 1: reset values, single miss -> req -> ack -> fill
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req", req, 0);
        chk("rst_fill_valid", fill_valid, 0);
        chk("rst_fill", fill, 0);
        chk("rst_sack_valid", sack_valid, 0);
        chk("rst_inv_valid", inv_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_bad_rid, 0);
        chk("rst_miss_retry", miss_retry, 0);
        exp_req.push_back({2'd0, 11'h155});
        do_miss(11'h155);
        @(negedge clk);
        chk("t1_req_latency", req_valid, 1);
        chk("t1_out1", outstanding, 1);
        fill_ack(2'd0, 11'h155, 14'd3);
        @(negedge clk);
        chk("t1_fill_latency", fill_valid, 1);
        chk("t1_out0", outstanding, 0);

        // 2: fill the table, 5th miss waits for the freed rid 2
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back({2'(i), 11'(i + 1)});
            do_miss(11'(i + 1));
        end
        @(negedge clk);
        chk("t2_out4", outstanding, 4);
        @(posedge clk) #1;
        miss_valid = 1; miss_hpaddr = 11'h005;
        exp_req.push_back({2'd2, 11'h005});
        repeat (3) begin @(negedge clk); chk("t2_full_retry", miss_retry, 1); end
        @(posedge clk) #1;
        ack_valid = 1; ack = mk_ack(2'd2, 11'h003, 14'h22, 8'h5A);
        exp_fill.push_back(mk_ack(2'd2, 11'h003, 14'h22, 8'h5A));
        @(negedge clk);
        chk("t2_retry_on_free_cycle", miss_retry, 1);
        @(posedge clk) #1;
        ack_valid = 0;
        @(negedge clk);
        chk("t2_rid_reusable", miss_retry, 0);
        chk("t2_out3", outstanding, 3);
        @(posedge clk) #1;
        miss_valid = 0;
        @(negedge clk);
        chk("t2_req_rid2_valid", req_valid, 1);
        chk("t2_out4_again", outstanding, 4);
        fill_ack(2'd0, 11'h001, 14'h100);
        fill_ack(2'd1, 11'h002, 14'h101);
        fill_ack(2'd3, 11'h004, 14'h103);
        fill_ack(2'd2, 11'h005, 14'h102);
        @(negedge clk);
        chk("t2_out_drained", outstanding, 0);

        // 3: req back-pressure holds payload and blocks misses
        @(posedge clk) #1;
        req_retry = 1;
        exp_req.push_back({2'd0, 11'h033});
        do_miss(11'h033);
        miss_valid = 1; miss_hpaddr = 11'h034;
        exp_req.push_back({2'd1, 11'h034});
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", req_valid, 1);
            chk("t3_hold_payload", req, {2'd0, 11'h033});
            chk("t3_miss_retry", miss_retry, 1);
        end
        @(posedge clk) #1;
        req_retry = 0;
        @(negedge clk);
        chk("t3_miss_released", miss_retry, 0);
        @(posedge clk) #1;
        miss_valid = 0;
        @(negedge clk);
        fill_ack(2'd0, 11'h033, 14'h200);
        fill_ack(2'd1, 11'h034, 14'h201);

        // 4: snoop poisons pending entry; its ack produces no fill
        exp_req.push_back({2'd0, 11'h0AA});
        do_miss(11'h0AA);
        exp_sack.push_back(2'd1);
        exp_inv.push_back(11'h0AA);
        do_snoop(2'd1, 11'h0AA);
        @(negedge clk);
        chk("t4_inv_pulse", inv_valid, 1);
        chk("t4_sack_valid", sack_valid, 1);
        @(negedge clk);
        chk("t4_inv_one_cycle", inv_valid, 0);
        do_ack(mk_ack(2'd0, 11'h0AA, 14'd5, 8'h00));
        repeat (3) begin @(negedge clk); chk("t4_no_fill", fill_valid, 0); end
        chk("t4_rid0_freed", outstanding, 0);
        chk("t4_no_err", err_bad_rid, 0);

        // 5: bad rid sets sticky error; fill back-pressure stalls acks without loss
        do_ack(mk_ack(2'd3, 11'h077, 14'd7, 8'h00));
        @(negedge clk);
        chk("t5_err_set", err_bad_rid, 1);
        chk("t5_bad_no_fill", fill_valid, 0);
        exp_req.push_back({2'd0, 11'h066});
        do_miss(11'h066);
        exp_req.push_back({2'd1, 11'h067});
        do_miss(11'h067);
        fill_retry = 1;
        fill_ack(2'd0, 11'h066, 14'd9);
        ack_valid = 1; ack = mk_ack(2'd1, 11'h067, 14'd10, 8'h5A);
        exp_fill.push_back(mk_ack(2'd1, 11'h067, 14'd10, 8'h5A));
        repeat (3) begin
            @(negedge clk);
            chk("t5_ack_retry", ack_retry, 1);
            chk("t5_fill_hold", fill, mk_ack(2'd0, 11'h066, 14'd9, 8'h5A));
        end
        @(posedge clk) #1;
        fill_retry = 0;
        @(negedge clk);
        chk("t5_ack_accepted", ack_retry, 0);
        @(posedge clk) #1;
        ack_valid = 0;
        @(negedge clk);
        chk("t5_second_fill", fill_valid, 1);
        chk("t5_err_sticky", err_bad_rid, 1);
        @(posedge clk) #1;
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("t5_err_cleared", err_bad_rid, 0);
        chk("t5_out_cleared", outstanding, 0);

        // 6: back-to-back duplicate misses
`ifdef L1TLB_MISS_MERGE_EN
        exp_req.push_back({2'd0, 11'h0F0});
`else
        exp_req.push_back({2'd0, 11'h0F0});
        exp_req.push_back({2'd1, 11'h0F0});
`endif
        @(posedge clk) #1;
        miss_valid = 1; miss_hpaddr = 11'h0F0;
        @(negedge clk);
        chk("t6_first_accept", miss_retry, 0);
        @(posedge clk) #1;
        @(negedge clk);
        chk("t6_second_accept", miss_retry, 0);
        @(posedge clk) #1;
        miss_valid = 0;
        repeat (2) @(negedge clk);
`ifdef L1TLB_MISS_MERGE_EN
        chk("t6_outstanding", outstanding, 1);
        fill_ack(2'd0, 11'h0F0, 14'h300);
`else
        chk("t6_outstanding", outstanding, 2);
        fill_ack(2'd0, 11'h0F0, 14'h300);
        fill_ack(2'd1, 11'h0F0, 14'h301);
`endif
        repeat (4) @(negedge clk);
        chk("end_outstanding", outstanding, 0);
        chk("end_req_drained", exp_req.size(), 0);
        chk("end_fill_drained", exp_fill.size(), 0);
        chk("end_sack_drained", exp_sack.size(), 0);
        chk("end_inv_drained", exp_inv.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
